mem_arbiter: RTL and testbench

Shares one single-port, word-addressed synchronous memory between the core's instruction-fetch port and its load/store port. Grants at most one access per cycle with round-robin priority on contention. Tracks in-flight reads through a fixed-latency tag pipeline so read data is steered back to the requester that issued it. Sits between the core (pc_counter fetch path, load/store unit) and the unified memory macro.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/lat_tag_pipe.sv | 29 ++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: owner encoding,
// byte-enable width, legal read-latency range and the in-flight read tag.
package mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int BE_W    = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory-side bus of the
// arbiter; slave is the arbiter's view, master is the core/memory side.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) ();

    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    logic            d_req;
    logic            d_we;
    logic [BE_W-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/lat_tag_pipe.sv
// Fixed-latency shift register of {valid, owner} tags that follows each memory
// access so returning read data can be steered to the port that issued it.
module lat_tag_pipe
    import mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [LAT];

    // NOTE: this is a handful of flops rather than a RAM, so every stage is
    // cleared on reset; that is what drops reads still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port, with tagged read return.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    owner_e          prio;
    logic            if_gnt;
    logic            d_gnt;
    logic            mem_en;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    tag_t            tag_in;
    tag_t            tag_out;
    logic            if_rvalid;
    logic            d_rvalid;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (bus.if_req && bus.d_req) begin
                if (prio == OWN_D) d_gnt  = 1'b1;
                else               if_gnt = 1'b1;
            end else begin
                if_gnt = bus.if_req;
                d_gnt  = bus.d_req;
            end
        end
    end

    // The pointer always moves to the port that just lost (or did not ask),
    // so a lone requester never starves a competitor that shows up later.
    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset)       prio <= OWN_D;
        else if (d_gnt)  prio <= OWN_IF;
        else if (if_gnt) prio <= OWN_D;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.d_we;
            mem_be    = bus.d_be;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_be    = '1;
            mem_addr  = bus.if_addr;
        end
    end

    // Stores travel down the pipe as bubbles so read tags stay aligned with
    // the memory's fixed read latency.
    assign tag_in = '{valid: if_gnt | (d_gnt & ~bus.d_we),
                      owner: d_gnt ? OWN_D : OWN_IF};

    lat_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign if_rvalid = ~reset & tag_out.valid & (tag_out.owner == OWN_IF);
    assign d_rvalid  = ~reset & tag_out.valid & (tag_out.owner == OWN_D);

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances (LAT 1..3) share one
// stimulus; a memory model per latency and a read-return scoreboard.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;

    mem_arbiter_if #(.AW(8), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(8), .DW(32)) bus2 ();
    mem_arbiter_if #(.AW(8), .DW(32)) bus3 ();

    mem_arbiter #(.AW(8), .DW(32), .LAT(1)) u_lat1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_arbiter #(.AW(8), .DW(32), .LAT(2)) u_lat2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_arbiter #(.AW(8), .DW(32), .LAT(3)) u_lat3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus1.if_req = if_req;  assign bus2.if_req = if_req;  assign bus3.if_req = if_req;
    assign bus1.if_addr = if_addr; assign bus2.if_addr = if_addr; assign bus3.if_addr = if_addr;
    assign bus1.d_req = d_req;    assign bus2.d_req = d_req;    assign bus3.d_req = d_req;
    assign bus1.d_we = d_we;      assign bus2.d_we = d_we;      assign bus3.d_we = d_we;
    assign bus1.d_be = d_be;      assign bus2.d_be = d_be;      assign bus3.d_be = d_be;
    assign bus1.d_addr = d_addr;  assign bus2.d_addr = d_addr;  assign bus3.d_addr = d_addr;
    assign bus1.d_wdata = d_wdata; assign bus2.d_wdata = d_wdata; assign bus3.d_wdata = d_wdata;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [7:0]  mem_addr;
        logic [31:0] mem_wdata;
    } obs_t;

    obs_t       ob [3];
    obs_t       o;
    logic [1:0] sel = 2'd0;

    assign ob[0] = {bus1.if_gnt, bus1.if_rvalid, bus1.if_rdata, bus1.d_gnt, bus1.d_rvalid, bus1.d_rdata,
                    bus1.mem_en, bus1.mem_we, bus1.mem_be, bus1.mem_addr, bus1.mem_wdata};
    assign ob[1] = {bus2.if_gnt, bus2.if_rvalid, bus2.if_rdata, bus2.d_gnt, bus2.d_rvalid, bus2.d_rdata,
                    bus2.mem_en, bus2.mem_we, bus2.mem_be, bus2.mem_addr, bus2.mem_wdata};
    assign ob[2] = {bus3.if_gnt, bus3.if_rvalid, bus3.if_rdata, bus3.d_gnt, bus3.d_rvalid, bus3.d_rdata,
                    bus3.mem_en, bus3.mem_we, bus3.mem_be, bus3.mem_addr, bus3.mem_wdata};
    assign o = ob[sel];

    // Memory macro model: word n holds 32'h1000+n after reset, except word 5 = 0.
    logic [31:0]      mem [256];
    logic [31:0]      rp1;
    logic [1:0][31:0] rp2;
    logic [2:0][31:0] rp3;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 5) ? 32'h0 : 32'h1000 + i;
        end else if (o.mem_en && o.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (o.mem_be[b]) mem[o.mem_addr][8*b +: 8] <= o.mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        rp1    <= (bus1.mem_en && !bus1.mem_we) ? mem[bus1.mem_addr] : 32'hBAD0_0001;
        rp2[0] <= (bus2.mem_en && !bus2.mem_we) ? mem[bus2.mem_addr] : 32'hBAD0_0002;
        rp2[1] <= rp2[0];
        rp3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem[bus3.mem_addr] : 32'hBAD0_0003;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    assign bus1.mem_rdata = rp1;
    assign bus2.mem_rdata = rp2[1];
    assign bus3.mem_rdata = rp3[2];

    // Read-return scoreboard: owner, data and the cycle it must appear in.
    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o.if_rvalid && o.d_rvalid) begin
            total++; bad++;
            $display("FAIL rv_both cyc=%0d if_rvalid=1 d_rvalid=1 required at most one", cyc);
        end else if (o.if_rvalid || o.d_rvalid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL rv_unexpected cyc=%0d if_rvalid=%0b d_rvalid=%0b required none",
                         cyc, o.if_rvalid, o.d_rvalid);
            end else begin
                mon_e   = sbq.pop_front();
                mon_act = o.d_rvalid ? o.d_rdata : o.if_rdata;
                if (o.d_rvalid !== mon_e.owner || mon_act !== mon_e.data || cyc != mon_e.due) begin
                    bad++;
                    $display("FAIL rv_data cyc=%0d got owner=%0b data=%h, required owner=%0b data=%h cyc=%0d",
                             cyc, o.d_rvalid, mon_act, mon_e.owner, mon_e.data, mon_e.due);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL rv_missing cyc=%0d no rvalid, required owner=%0b data=%h", cyc, sbq[0].owner, sbq[0].data);
            void'(sbq.pop_front());
        end
        total++;
        if ((!o.if_rvalid && o.if_rdata !== 32'h0) || (!o.d_rvalid && o.d_rdata !== 32'h0)) begin
            bad++;
            $display("FAIL rdata_idle cyc=%0d if_rdata=%h d_rdata=%h required 0 when not valid",
                     cyc, o.if_rdata, o.d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 12 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain %0d reads outstanding, required 0", sbq.size());
            sbq.delete();
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        sel = 2'd0;
        reset = 1'b1;
        if_req = 1'b1; if_addr = 8'd3;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 8'd9; d_wdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt if_gnt/d_gnt=%b required 00", {o.if_gnt, o.d_gnt});
        end
        total++;
        if ({o.mem_en, o.mem_we} !== 2'b00) begin
            bad++; $display("FAIL reset_mem_en_we got %b required 00", {o.mem_en, o.mem_we});
        end
        total++;
        if ({o.mem_be, o.mem_addr, o.mem_wdata} !== 44'h0) begin
            bad++; $display("FAIL reset_mem_bus be=%h addr=%h wdata=%h required 0", o.mem_be, o.mem_addr, o.mem_wdata);
        end
        total++;
        if ({o.if_rvalid, o.d_rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_rvalid got %b required 00", {o.if_rvalid, o.d_rvalid});
        end
        tick();
        do_reset();
    endtask

    task automatic test_fetch_stream();
        sel = 2'd0;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            if_req = 1'b1; if_addr = 8'(n);
            @(negedge clk);
            total++;
            if ({o.if_gnt, o.d_gnt, o.mem_en, o.mem_we, o.mem_be, o.mem_addr} !== {4'b1010, 4'hF, 8'(n)}) begin
                bad++;
                $display("FAIL fetch_gnt n=%0d got gnt=%b en=%b we=%b be=%h addr=%h, required 1/0 1 0 f %h",
                         n, {o.if_gnt, o.d_gnt}, o.mem_en, o.mem_we, o.mem_be, o.mem_addr, 8'(n));
            end
            sbq.push_back('{owner: 1'b0, data: 32'h1000 + n, due: cyc + 1});
            tick();
        end
        drain();
    endtask

    task automatic test_contention();
        logic exp_d;
        sel = 2'd0;
        do_reset();
        if_req = 1'b1; if_addr = 8'd1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 8'd2;
        for (int i = 0; i < 6; i++) begin
            exp_d = (i % 2 == 0);
            @(negedge clk);
            total++;
            if ({o.if_gnt, o.d_gnt, o.mem_addr} !== {!exp_d, exp_d, exp_d ? 8'd2 : 8'd1}) begin
                bad++;
                $display("FAIL contention_gnt i=%0d got if/d=%b addr=%h, required if/d=%b addr=%h",
                         i, {o.if_gnt, o.d_gnt}, o.mem_addr, {!exp_d, exp_d}, exp_d ? 8'd2 : 8'd1);
            end
            sbq.push_back('{owner: exp_d, data: exp_d ? 32'h1002 : 32'h1001, due: cyc + 1});
            tick();
        end
        drain();
    endtask

    task automatic test_store_load();
        sel = 2'd0;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 8'd5; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({o.d_gnt, o.if_gnt, o.mem_en, o.mem_we, o.mem_be, o.mem_addr, o.mem_wdata} !==
            {4'b1011, 4'b0011, 8'd5, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL store_issue got gnt=%b en=%b we=%b be=%b addr=%h wdata=%h, required d 1 1 0011 05 deadbeef",
                     {o.d_gnt, o.if_gnt}, o.mem_en, o.mem_we, o.mem_be, o.mem_addr, o.mem_wdata);
        end
        tick();
        d_we = 1'b0; d_be = 4'hF;
        @(negedge clk);
        total++;
        if ({o.d_gnt, o.mem_we, o.mem_addr} !== {2'b10, 8'd5}) begin
            bad++;
            $display("FAIL load_issue got d_gnt=%b we=%b addr=%h, required 1 0 05", o.d_gnt, o.mem_we, o.mem_addr);
        end
        sbq.push_back('{owner: 1'b1, data: 32'h0000_BEEF, due: cyc + 1});
        tick();
        drain();
    endtask

    task automatic test_be_zero();
        sel = 2'd0;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000; d_addr = 8'd7; d_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++;
        if ({o.d_gnt, o.mem_en, o.mem_we, o.mem_be} !== {3'b111, 4'b0000}) begin
            bad++;
            $display("FAIL be0_issue got d_gnt=%b en=%b we=%b be=%b, required 1 1 1 0000",
                     o.d_gnt, o.mem_en, o.mem_we, o.mem_be);
        end
        tick();
        d_we = 1'b0; d_be = 4'hF;
        @(negedge clk);
        sbq.push_back('{owner: 1'b1, data: 32'h1007, due: cyc + 1});
        tick();
        drain();
    endtask

    task automatic test_lat3();
        sel = 2'd2;
        do_reset();
        if_req = 1'b1; if_addr = 8'd2;
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt} !== 2'b10) begin
            bad++; $display("FAIL lat3_fetch_gnt got %b required 10", {o.if_gnt, o.d_gnt});
        end
        sbq.push_back('{owner: 1'b0, data: 32'h1002, due: cyc + 3});
        tick();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 8'd3;
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt} !== 2'b01) begin
            bad++; $display("FAIL lat3_data_gnt got %b required 01", {o.if_gnt, o.d_gnt});
        end
        sbq.push_back('{owner: 1'b1, data: 32'h1003, due: cyc + 3});
        tick();
        drain();
    endtask

    task automatic test_reset_inflight();
        sel = 2'd1;
        do_reset();
        if_req = 1'b1; if_addr = 8'd0;
        @(negedge clk);
        total++;
        if (o.if_gnt !== 1'b1) begin
            bad++; $display("FAIL rst_pre_fetch if_gnt=%b required 1", o.if_gnt);
        end
        tick();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 8'd1;
        @(negedge clk);
        total++;
        if (o.d_gnt !== 1'b1) begin
            bad++; $display("FAIL rst_pre_data d_gnt=%b required 1", o.d_gnt);
        end
        tick();
        // Both reads are in flight; prio now points at fetch.
        reset = 1'b1;
        if_req = 1'b1; if_addr = 8'd4; d_addr = 8'd2;
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt, o.mem_en, o.mem_we, o.if_rvalid, o.d_rvalid} !== 6'b0 ||
            {o.mem_be, o.mem_addr, o.mem_wdata} !== 44'h0) begin
            bad++;
            $display("FAIL rst_outputs gnt=%b en=%b we=%b rv=%b be=%h addr=%h required all 0",
                     {o.if_gnt, o.d_gnt}, o.mem_en, o.mem_we, {o.if_rvalid, o.d_rvalid}, o.mem_be, o.mem_addr);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt, o.if_rvalid, o.d_rvalid} !== 4'b0100) begin
            bad++;
            $display("FAIL rst_first_contention gnt if/d=%b rv=%b, required gnt 01 rv 00",
                     {o.if_gnt, o.d_gnt}, {o.if_rvalid, o.d_rvalid});
        end
        sbq.push_back('{owner: 1'b1, data: 32'h1002, due: cyc + 2});
        tick();
        @(negedge clk);
        total++;
        if ({o.if_gnt, o.d_gnt, o.if_rvalid, o.d_rvalid} !== 4'b1000) begin
            bad++;
            $display("FAIL rst_second_contention gnt if/d=%b rv=%b, required gnt 10 rv 00",
                     {o.if_gnt, o.d_gnt}, {o.if_rvalid, o.d_rvalid});
        end
        sbq.push_back('{owner: 1'b0, data: 32'h1004, due: cyc + 2});
        tick();
        drain();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_stream();
        test_contention();
        test_store_load();
        test_be_zero();
        test_lat3();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
